cdb_arbiter: RTL and testbench

- Complete-stage arbiter directly downstream of the functional units (ALUs, mult, load).
- Collects finished-result packets from NUM_FU units and grants at most CDB_WIDTH of them per cycle onto the registered common data bus.
- Back-pressures every losing unit through its stall input; the mult unit holds its final-stage result while stalled.
- Round-robin priority guarantees bounded wait for every unit.

---
 rtl/cdb_arbiter.sv | 84 ++++++++
 tb/tb_cdb_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Complete-stage arbiter: grants up to CDB_WIDTH finished FU results per cycle
// onto a registered common data bus, round-robin from rr_ptr, stalling the losers.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int CDB_WIDTH = 2,
    parameter int PACK_W    = 32,
    localparam int PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        squash,
    input  logic [NUM_FU-1:0]           fu_data_ready,
    input  logic [NUM_FU*PACK_W-1:0]    fu_pack,
    output logic [NUM_FU-1:0]           fu_stall,
    output logic [CDB_WIDTH-1:0]        cdb_valid,
    output logic [CDB_WIDTH*PACK_W-1:0] cdb_pack
);

    logic [PTR_W-1:0]            rr_ptr_reg;
    logic [PTR_W-1:0]            rr_ptr_next;
    logic [CDB_WIDTH-1:0]        cdb_valid_reg;
    logic [CDB_WIDTH-1:0]        cdb_valid_next;
    logic [CDB_WIDTH*PACK_W-1:0] cdb_pack_reg;
    logic [CDB_WIDTH*PACK_W-1:0] cdb_pack_next;
    logic [NUM_FU-1:0]           granted;
    logic [PTR_W-1:0]            idx;
    logic [PTR_W-1:0]            last_idx;
    logic                        any_grant;
    int                          fill;

    // Walk the FUs in rotated order; the k-th requester found fills slot k.
    always_comb begin
        granted        = '0;
        cdb_valid_next = '0;
        cdb_pack_next  = '0;
        idx            = rr_ptr_reg;
        last_idx       = rr_ptr_reg;
        fill           = 0;
        for (int off = 0; off < NUM_FU; off++) begin
            idx = PTR_W'((int'(rr_ptr_reg) + off) % NUM_FU);
            if (fu_data_ready[idx] && (fill < CDB_WIDTH)) begin
                granted[idx] = 1'b1;
                for (int k = 0; k < CDB_WIDTH; k++) begin
                    if (k == fill) begin
                        cdb_valid_next[k]                 = 1'b1;
                        cdb_pack_next[k*PACK_W +: PACK_W] = fu_pack[idx*PACK_W +: PACK_W];
                    end
                end
                last_idx = idx;
                fill     = fill + 1;
            end
        end
        any_grant   = (fill != 0);
        rr_ptr_next = PTR_W'((int'(last_idx) + 1) % NUM_FU);
    end

    // Squash and reset flush the FUs too, so nobody is told to hold.
    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_stall
            assign fu_stall[gi] = fu_data_ready[gi] & ~granted[gi] & ~squash & ~reset;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_reg    <= '0;
            cdb_valid_reg <= '0;
            cdb_pack_reg  <= '0;
        end else if (squash) begin
            cdb_valid_reg <= '0;
            cdb_pack_reg  <= '0;
        end else begin
            cdb_valid_reg <= cdb_valid_next;
            cdb_pack_reg  <= cdb_pack_next;
            if (any_grant) begin
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

    assign cdb_valid = cdb_valid_reg;
    assign cdb_pack  = cdb_pack_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a randomized FU population
// checked against a queue-based round-robin reference model.
module tb_cdb_arbiter;

    localparam int N           = 4;
    localparam int W           = 2;
    localparam int MULT_STAGES = 3;
    localparam int FAIR        = (N + W - 1) / W;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         squash = 1'b0;
    logic [3:0]   rdy = '0;
    logic [31:0]  pk [4];
    logic [127:0] fu_pack;
    logic [3:0]   fu_stall;
    logic [1:0]   cdb_valid;
    logic [63:0]  cdb_pack;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int         rr_m = 0;
    int         m_src[$];
    logic [3:0] m_gnt;
    logic [3:0] e_stall;
    logic [1:0] e_valid;
    logic [63:0] e_pack;

    assign fu_pack = {pk[3], pk[2], pk[1], pk[0]};

    cdb_arbiter #(.NUM_FU(N), .CDB_WIDTH(W), .PACK_W(32)) dut (
        .clock(clock),
        .reset(reset),
        .squash(squash),
        .fu_data_ready(rdy),
        .fu_pack(fu_pack),
        .fu_stall(fu_stall),
        .cdb_valid(cdb_valid),
        .cdb_pack(cdb_pack)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic [3:0] r, input logic sq, input logic rst);
        @(negedge clock);
        rdy    = r;
        squash = sq;
        reset  = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Requesters listed in rotated order from the pointer; the first W win.
    task automatic model(input logic [3:0] r, input logic sq);
        int order[$];
        m_gnt   = '0;
        e_valid = '0;
        e_pack  = '0;
        m_src.delete();
        if (!sq) begin
            for (int i = 0; i < N; i++) begin
                if (r[(rr_m + i) % N]) order.push_back((rr_m + i) % N);
            end
            while (order.size() > 0 && m_src.size() < W) begin
                m_src.push_back(order.pop_front());
                m_gnt[m_src[m_src.size()-1]] = 1'b1;
            end
            for (int k = 0; k < m_src.size(); k++) begin
                e_valid[k]        = 1'b1;
                e_pack[k*32 +: 32] = pk[m_src[k]];
            end
            if (m_src.size() > 0) rr_m = (m_src[m_src.size()-1] + 1) % N;
        end
        e_stall = sq ? 4'b0000 : (r & ~m_gnt);
    endtask

    task automatic test_reset();
        drive(4'b1111, 1'b0, 1'b1);
        n_cmp++; if (fu_stall !== 4'b0000) begin n_bad++; $display("FAIL reset_stall got %b want 0000", fu_stall); end
        tick();
        drive(4'b0000, 1'b0, 1'b1);
        tick();
        n_cmp++; if (cdb_valid !== 2'b00) begin n_bad++; $display("FAIL reset_valid got %b want 00", cdb_valid); end
        n_cmp++; if (cdb_pack !== 64'h0) begin n_bad++; $display("FAIL reset_pack got %h want 0", cdb_pack); end
        drive(4'b0000, 1'b0, 1'b0);
        n_cmp++; if (fu_stall !== 4'b0000) begin n_bad++; $display("FAIL idle_stall got %b want 0000", fu_stall); end
        tick();
        $display("test_reset done valid=%b pack=%h", cdb_valid, cdb_pack);
    endtask

    task automatic test_single();
        pk[2] = 32'h0000_1234;
        drive(4'b0100, 1'b0, 1'b0);
        n_cmp++; if (fu_stall !== 4'b0000) begin n_bad++; $display("FAIL single_stall got %b want 0000", fu_stall); end
        tick();
        n_cmp++; if (cdb_valid !== 2'b01) begin n_bad++; $display("FAIL single_valid got %b want 01", cdb_valid); end
        n_cmp++; if (cdb_pack !== 64'h0000_0000_0000_1234) begin n_bad++; $display("FAIL single_pack got %h want 1234", cdb_pack); end
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        n_cmp++; if (cdb_valid !== 2'b00) begin n_bad++; $display("FAIL single_after got %b want 00", cdb_valid); end
        $display("test_single done");
    endtask

    task automatic test_all_four();
        drive(4'b0000, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < N; i++) pk[i] = 32'hA000_0000 + i;
        drive(4'b1111, 1'b0, 1'b0);
        n_cmp++; if (fu_stall !== 4'b1100) begin n_bad++; $display("FAIL all_stall0 got %b want 1100", fu_stall); end
        tick();
        n_cmp++; if (cdb_valid !== 2'b11) begin n_bad++; $display("FAIL all_valid1 got %b want 11", cdb_valid); end
        n_cmp++; if (cdb_pack !== {pk[1], pk[0]}) begin n_bad++; $display("FAIL all_pack1 got %h want %h", cdb_pack, {pk[1], pk[0]}); end
        drive(4'b1100, 1'b0, 1'b0);
        n_cmp++; if (fu_stall !== 4'b0000) begin n_bad++; $display("FAIL all_stall1 got %b want 0000", fu_stall); end
        tick();
        n_cmp++; if (cdb_pack !== {pk[3], pk[2]} || cdb_valid !== 2'b11) begin n_bad++; $display("FAIL all_pack2 got %b/%h want 11/%h", cdb_valid, cdb_pack, {pk[3], pk[2]}); end
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        $display("test_all_four done");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < N; i++) pk[i] = 32'hB000_0000 + i;
        drive(4'b0100, 1'b0, 1'b0);
        tick();
        drive(4'b1011, 1'b0, 1'b0);
        n_cmp++; if (fu_stall !== 4'b0010) begin n_bad++; $display("FAIL wrap_stall got %b want 0010", fu_stall); end
        tick();
        n_cmp++; if (cdb_valid !== 2'b11 || cdb_pack !== {pk[0], pk[3]}) begin n_bad++; $display("FAIL wrap_pack got %b/%h want 11/%h", cdb_valid, cdb_pack, {pk[0], pk[3]}); end
        drive(4'b0010, 1'b0, 1'b0);
        n_cmp++; if (fu_stall !== 4'b0000) begin n_bad++; $display("FAIL wrap_stall2 got %b want 0000", fu_stall); end
        tick();
        n_cmp++; if (cdb_valid !== 2'b01 || cdb_pack[31:0] !== pk[1]) begin n_bad++; $display("FAIL wrap_fu1 got %b/%h want 01/%h", cdb_valid, cdb_pack[31:0], pk[1]); end
        $display("test_wrap done");
    endtask

    task automatic test_squash();
        for (int i = 0; i < N; i++) pk[i] = 32'hC000_0000 + i;
        drive(4'b1111, 1'b1, 1'b0);
        n_cmp++; if (fu_stall !== 4'b0000) begin n_bad++; $display("FAIL squash_stall got %b want 0000", fu_stall); end
        tick();
        n_cmp++; if (cdb_valid !== 2'b00 || cdb_pack !== 64'h0) begin n_bad++; $display("FAIL squash_cdb got %b/%h want 00/0", cdb_valid, cdb_pack); end
        drive(4'b1111, 1'b0, 1'b0);
        n_cmp++; if (fu_stall !== 4'b0011) begin n_bad++; $display("FAIL squash_rr got %b want 0011", fu_stall); end
        tick();
        n_cmp++; if (cdb_valid !== 2'b11 || cdb_pack !== {pk[3], pk[2]}) begin n_bad++; $display("FAIL squash_after got %b/%h want 11/%h", cdb_valid, cdb_pack, {pk[3], pk[2]}); end
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        $display("test_squash done");
    endtask

    // FU0/FU1 are ALUs, FU2 a MULT_STAGES-deep multiplier that holds while stalled.
    task automatic test_mult();
        logic       mul_done = 1'b0;
        logic       mul_rdy;
        logic       alu_rdy;
        int         stall_cycles = 0;
        int         seen = 0;
        int         seen_cyc = -1;
        logic [31:0] a = 32'd3;
        logic [31:0] b = 32'd4;
        pk[0] = 32'd5;
        pk[1] = 32'd7;
        pk[2] = a * b;
        pk[3] = 32'd0;
        for (int cyc = 0; cyc <= MULT_STAGES + 3; cyc++) begin
            mul_rdy = (cyc >= MULT_STAGES - 1) && !mul_done;
            alu_rdy = (cyc == MULT_STAGES - 1);
            drive({1'b0, mul_rdy, alu_rdy, alu_rdy}, 1'b0, 1'b0);
            if (mul_rdy && fu_stall[2]) stall_cycles++;
            if (mul_rdy && !fu_stall[2]) mul_done = 1'b1;
            tick();
            if (cyc == MULT_STAGES - 1) begin
                n_cmp++; if (cdb_valid !== 2'b11 || cdb_pack !== {32'd7, 32'd5}) begin n_bad++; $display("FAIL mult_alus got %b/%h want 11/%h", cdb_valid, cdb_pack, {32'd7, 32'd5}); end
            end
            for (int k = 0; k < W; k++) begin
                if (cdb_valid[k] && cdb_pack[k*32 +: 32] == 32'd12) begin
                    seen++;
                    seen_cyc = cyc + 1;
                end
            end
        end
        n_cmp++; if (stall_cycles !== 1) begin n_bad++; $display("FAIL mult_stalls got %0d want 1", stall_cycles); end
        n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL mult_once got %0d want 1", seen); end
        n_cmp++; if (seen_cyc !== MULT_STAGES + 1) begin n_bad++; $display("FAIL mult_latency got %0d want %0d", seen_cyc, MULT_STAGES + 1); end
        $display("test_mult done result_cycle=%0d", seen_cyc);
    endtask

    task automatic test_random();
        logic [3:0] pend = '0;
        logic [3:0] cool = '0;
        logic       sq;
        int         seq = 0;
        int         wait_cnt[4] = '{0, 0, 0, 0};
        drive(4'b0000, 1'b0, 1'b1);
        tick();
        rr_m = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && !cool[i] && $urandom_range(0, 99) < 60) begin
                    pend[i] = 1'b1;
                    pk[i]   = {8'(i), 24'(seq)};
                    seq++;
                end
            end
            sq = ($urandom_range(0, 19) == 0);
            drive(pend, sq, 1'b0);
            model(pend, sq);
            n_cmp++; if (fu_stall !== e_stall) begin n_bad++; $display("FAIL rand_stall cyc %0d got %b want %b", cyc, fu_stall, e_stall); end
            for (int i = 0; i < N; i++) begin
                if (fu_stall[i]) begin
                    wait_cnt[i]++;
                    n_cmp++; if (wait_cnt[i] >= FAIR) begin n_bad++; $display("FAIL rand_fair fu %0d waited %0d want <%0d", i, wait_cnt[i], FAIR); end
                end else begin
                    wait_cnt[i] = 0;
                end
            end
            tick();
            n_cmp++; if (cdb_valid !== e_valid || cdb_pack !== e_pack) begin n_bad++; $display("FAIL rand_cdb cyc %0d got %b/%h want %b/%h", cyc, cdb_valid, cdb_pack, e_valid, e_pack); end
            $display("rand cyc %0d req %b sq %b stall %b cdb %b %h", cyc, pend, sq, fu_stall, cdb_valid, cdb_pack);
            cool = sq ? 4'b0000 : m_gnt;
            pend = sq ? 4'b0000 : (pend & ~m_gnt);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) pk[i] = '0;
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_squash();
        test_mult();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
